// File: rtl/ram_bwe_pipe_if.sv
// Request/response bundle for ram_bwe_pipe: read port, write port with group enables, and status.
// o_parity_err exists only when RAM_BWE_PIPE_PARITY_EN is defined.
interface ram_bwe_pipe_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int NG         = 8
);
    logic                  i_mem_re;
    logic [ADDR_WIDTH-1:0] i_mem_raddr;
    logic [DATA_WIDTH-1:0] o_mem_rdata;
    logic                  o_mem_rvalid;
    logic                  i_mem_we;
    logic [ADDR_WIDTH-1:0] i_mem_waddr;
    logic [DATA_WIDTH-1:0] i_mem_wdata;
    logic [NG-1:0]         i_mem_bwe;
    logic                  o_init_busy;
`ifdef RAM_BWE_PIPE_PARITY_EN
    logic                  o_parity_err;
`endif

    modport master (
        output i_mem_re, i_mem_raddr, i_mem_we, i_mem_waddr, i_mem_wdata, i_mem_bwe,
        input  o_mem_rdata, o_mem_rvalid, o_init_busy
`ifdef RAM_BWE_PIPE_PARITY_EN
        , input o_parity_err
`endif
    );

    modport slave (
        input  i_mem_re, i_mem_raddr, i_mem_we, i_mem_waddr, i_mem_wdata, i_mem_bwe,
        output o_mem_rdata, o_mem_rvalid, o_init_busy
`ifdef RAM_BWE_PIPE_PARITY_EN
        , output o_parity_err
`endif
    );
endinterface

// File: rtl/ram_bwe_pipe.sv
// Single-clock 1R1W RAM: group write enables, 1/2-cycle read latency, write-to-read bypass and
// a post-reset clear sequencer. Optional per-group even parity: define RAM_BWE_PIPE_PARITY_EN.
module ram_bwe_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int BWE_GROUP  = 8,
    parameter int RD_LATENCY = 1,
    parameter int BYPASS     = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    ram_bwe_pipe_if.slave bus
);
    localparam int NG    = (BWE_GROUP == 0) ? 1 : DATA_WIDTH / BWE_GROUP;
    localparam int GW    = (BWE_GROUP == 0) ? DATA_WIDTH : BWE_GROUP;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_chk_lat
        $error("ram_bwe_pipe: RD_LATENCY must be 1 or 2");
    end
    if (BWE_GROUP != 0 && (DATA_WIDTH % BWE_GROUP) != 0) begin : g_chk_grp
        $error("ram_bwe_pipe: BWE_GROUP must divide DATA_WIDTH");
    end
    if ((2 ** ADDR_WIDTH) < DEPTH) begin : g_chk_addr
        $error("ram_bwe_pipe: ADDR_WIDTH too small for DEPTH");
    end

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      clr_cnt, clr_cnt_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  run, rd_fire, wr_fire, rd_in_range, collide;
    logic [IDX_W-1:0]      ridx, widx;
    logic [NG-1:0]         grp_en;
    logic [DATA_WIDTH-1:0] merged, rd_word;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            ST_INIT: begin
                if (clr_cnt == LAST_IDX) begin
                    state_nxt   = ST_RUN;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    assign bus.o_init_busy = (state == ST_INIT);

    // Requests are honoured only in RUN and never on an edge that is itself resetting.
    assign run         = (state == ST_RUN) && !i_rst;
    assign ridx        = bus.i_mem_raddr[IDX_W-1:0];
    assign widx        = bus.i_mem_waddr[IDX_W-1:0];
    assign rd_in_range = ({1'b0, bus.i_mem_raddr} < DEPTH_A);
    assign rd_fire     = run && bus.i_mem_re;
    assign wr_fire     = run && bus.i_mem_we && ({1'b0, bus.i_mem_waddr} < DEPTH_A);
    assign collide     = wr_fire && bus.i_mem_re && (bus.i_mem_waddr == bus.i_mem_raddr);
    assign grp_en      = (BWE_GROUP == 0) ? {NG{1'b1}} : bus.i_mem_bwe;

    always_comb begin
        merged = mem[ridx];
        for (int g = 0; g < NG; g++) begin
            if (grp_en[g]) merged[g*GW +: GW] = bus.i_mem_wdata[g*GW +: GW];
        end
        rd_word = '0;
        if (rd_in_range) rd_word = (BYPASS != 0 && collide) ? merged : mem[ridx];
    end

    // NOTE: the storage array has no reset; the INIT sequence clears it one word per cycle.
    always_ff @(posedge i_clk) begin
        if (state == ST_INIT) begin
            mem[clr_cnt] <= '0;
        end else if (wr_fire) begin
            for (int g = 0; g < NG; g++) begin
                if (grp_en[g]) mem[widx][g*GW +: GW] <= bus.i_mem_wdata[g*GW +: GW];
            end
        end
    end

`ifdef RAM_BWE_PIPE_PARITY_EN
    logic [NG-1:0] par_mem [DEPTH];
    logic [NG-1:0] wr_par, merged_par;
    logic          rd_perr, s1_perr;

    function automatic logic [NG-1:0] grp_parity(input logic [DATA_WIDTH-1:0] d);
        grp_parity = '0;
        for (int g = 0; g < NG; g++) grp_parity[g] = ^d[g*GW +: GW];
    endfunction

    assign wr_par = grp_parity(bus.i_mem_wdata);

    always_comb begin
        merged_par = par_mem[ridx];
        for (int g = 0; g < NG; g++) begin
            if (grp_en[g]) merged_par[g] = wr_par[g];
        end
        rd_perr = 1'b0;
        if (rd_in_range)
            rd_perr = |(grp_parity(rd_word) ^
                        ((BYPASS != 0 && collide) ? merged_par : par_mem[ridx]));
    end

    always_ff @(posedge i_clk) begin
        if (state == ST_INIT) begin
            par_mem[clr_cnt] <= '0;
        end else if (wr_fire) begin
            for (int g = 0; g < NG; g++) begin
                if (grp_en[g]) par_mem[widx][g] <= wr_par[g];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) s1_perr <= 1'b0;
        else       s1_perr <= rd_fire && rd_perr;
    end
`endif

    // Stage 1: data updates only on an accepted read so the output holds between results.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) s1_data <= rd_word;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  s2_valid;
        logic [DATA_WIDTH-1:0] s2_data;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_data <= s1_data;
            end
        end

        assign bus.o_mem_rvalid = s2_valid;
        assign bus.o_mem_rdata  = s2_data;
`ifdef RAM_BWE_PIPE_PARITY_EN
        logic s2_perr;
        always_ff @(posedge i_clk) begin
            if (i_rst) s2_perr <= 1'b0;
            else       s2_perr <= s1_perr;
        end
        assign bus.o_parity_err = s2_perr;
`endif
    end else begin : g_lat1
        assign bus.o_mem_rvalid = s1_valid;
        assign bus.o_mem_rdata  = s1_data;
`ifdef RAM_BWE_PIPE_PARITY_EN
        assign bus.o_parity_err = s1_perr;
`endif
    end
endmodule

// File: tb/tb_ram_bwe_pipe.sv
// Bench for ram_bwe_pipe: two instances (latency 2 + bypass, latency 1 without bypass) driven in
// lockstep with DEPTH=16 so the clear sequence, out-of-range addresses and collisions are visible.
module tb_ram_bwe_pipe;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int AW    = 5;
    localparam int NG    = 8;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    ram_bwe_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NG(NG)) bus_a ();
    ram_bwe_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NG(NG)) bus_b ();

    ram_bwe_pipe #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .BWE_GROUP(8),
                   .RD_LATENCY(2), .BYPASS(1))
        dut_a (.i_clk(i_clk), .i_rst(i_rst), .bus(bus_a));

    ram_bwe_pipe #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .BWE_GROUP(8),
                   .RD_LATENCY(1), .BYPASS(0))
        dut_b (.i_clk(i_clk), .i_rst(i_rst), .bus(bus_b));

    typedef struct {
        logic          re;
        logic [AW-1:0] raddr;
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [NG-1:0] bwe;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    vec_t          vec[$];
    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;

    function automatic vec_t mk(input logic re, input logic [AW-1:0] ra, input logic we,
                                input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic [NG-1:0] be, input logic [DW-1:0] ea,
                                input logic [DW-1:0] eb);
        vec_t v;
        v.re = re; v.raddr = ra; v.we = we; v.waddr = wa;
        v.wdata = wd; v.bwe = be; v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic re, input logic [AW-1:0] ra, input logic we,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [NG-1:0] be);
        bus_a.i_mem_re = re; bus_a.i_mem_raddr = ra; bus_a.i_mem_we = we;
        bus_a.i_mem_waddr = wa; bus_a.i_mem_wdata = wd; bus_a.i_mem_bwe = be;
        bus_b.i_mem_re = re; bus_b.i_mem_raddr = ra; bus_b.i_mem_we = we;
        bus_b.i_mem_waddr = wa; bus_b.i_mem_wdata = wd; bus_b.i_mem_bwe = be;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic va, input logic vb);
        check_bit({tag, " a.rvalid"}, bus_a.o_mem_rvalid, va);
        check({tag, " a.rdata"}, bus_a.o_mem_rdata, last_a);
        check_bit({tag, " b.rvalid"}, bus_b.o_mem_rvalid, vb);
        check({tag, " b.rdata"}, bus_b.o_mem_rdata, last_b);
    endtask

    // Single read; latency-1 instance answers after one edge, latency-2 instance after two.
    task automatic read_check(input string tag, input logic [AW-1:0] a,
                              input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        drive(1'b1, a, 1'b0, '0, '0, '0);
        tick();
        idle();
        last_b = eb;
        check_outs({tag, " c1"}, 1'b0, 1'b1);
        tick();
        last_a = ea;
        check_outs({tag, " c2"}, 1'b1, 1'b0);
    endtask

    // Releases reset and counts edges until busy drops; optionally pokes requests while busy.
    task automatic wait_clear(input string tag, input logic poke);
        int na = 0;
        int nb = 0;
        i_rst  = 1'b0;
        last_a = '0;
        last_b = '0;
        if (poke) drive(1'b1, 5'd3, 1'b1, 5'd3, 64'h5, 8'hFF);
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (na == 0 && !bus_a.o_init_busy) na = k;
            if (nb == 0 && !bus_b.o_init_busy) nb = k;
            if (na != 0 || nb != 0) idle();
            if (bus_a.o_init_busy) begin
                check_bit({tag, " busy a.rvalid"}, bus_a.o_mem_rvalid, 1'b0);
                check({tag, " busy a.rdata"}, bus_a.o_mem_rdata, '0);
            end
            if (bus_b.o_init_busy) begin
                check_bit({tag, " busy b.rvalid"}, bus_b.o_mem_rvalid, 1'b0);
                check({tag, " busy b.rdata"}, bus_b.o_mem_rdata, '0);
            end
            if (na != 0 && nb != 0) break;
        end
        idle();
        check({tag, " a.busy_cycles"}, DW'(na), DW'(DEPTH));
        check({tag, " b.busy_cycles"}, DW'(nb), DW'(DEPTH));
    endtask

    initial begin
        idle();
        i_rst = 1'b1;
        tick();
        tick();
        check_outs("reset", 1'b0, 1'b0);
        check_bit("reset a.busy", bus_a.o_init_busy, 1'b1);
        check_bit("reset b.busy", bus_b.o_init_busy, 1'b1);
`ifdef RAM_BWE_PIPE_PARITY_EN
        check_bit("reset a.perr", bus_a.o_parity_err, 1'b0);
`endif
        wait_clear("init", 1'b0);

        // Preload, confirm it stuck, then a one-cycle reset pulse must wipe everything.
        drive(1'b0, '0, 1'b1, 5'd3, 64'h5, 8'hFF);
        tick();
        drive(1'b0, '0, 1'b1, 5'd9, 64'h99, 8'hFF);
        tick();
        read_check("preload", 5'd3, 64'h5, 64'h5);
        i_rst = 1'b1;
        tick();
        last_a = '0;
        last_b = '0;
        check_outs("pulse", 1'b0, 1'b0);
        wait_clear("pulse", 1'b0);
        for (int a = 0; a < DEPTH; a++) read_check($sformatf("clr%0d", a), AW'(a), '0, '0);

        // Reset again, then re-assert with the clear counter at 8.
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        repeat (8) tick();
        i_rst = 1'b1;
        tick();
        wait_clear("mid", 1'b1);
        read_check("mid_rd3", 5'd3, '0, '0);

        vec.push_back(mk(0, 0,     1, 5'd1,  64'h1111_0000_0000_0001, 8'hFF, 0, 0));
        vec.push_back(mk(0, 0,     1, 5'd2,  64'h2222_0000_0000_0002, 8'hFF, 0, 0));
        vec.push_back(mk(0, 0,     1, 5'd3,  64'h3333_0000_0000_0003, 8'hFF, 0, 0));
        vec.push_back(mk(0, 0,     1, 5'd5,  64'h1122334455667788,    8'hFF, 0, 0));
        vec.push_back(mk(0, 0,     1, 5'd5,  64'hAAAAAAAAAAAAAAAA,    8'h0F, 0, 0));
        vec.push_back(mk(1, 5'd5,  0, 0, 0, 0, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA));
        vec.push_back(mk(1, 5'd1,  0, 0, 0, 0, 64'h1111_0000_0000_0001, 64'h1111_0000_0000_0001));
        vec.push_back(mk(1, 5'd2,  0, 0, 0, 0, 64'h2222_0000_0000_0002, 64'h2222_0000_0000_0002));
        vec.push_back(mk(1, 5'd3,  0, 0, 0, 0, 64'h3333_0000_0000_0003, 64'h3333_0000_0000_0003));
        vec.push_back(mk(0, 0,     0, 0, 0, 0, 0, 0));
        vec.push_back(mk(1, 5'd7,  1, 5'd7,  64'hFFFFFFFFFFFFFFFF, 8'h01, 64'hFF, 64'h0));
        vec.push_back(mk(1, 5'd7,  0, 0, 0, 0, 64'hFF, 64'hFF));
        vec.push_back(mk(0, 0,     1, 5'd20, 64'hDEAD, 8'hFF, 0, 0));
        vec.push_back(mk(1, 5'd20, 0, 0, 0, 0, 64'h0, 64'h0));
        vec.push_back(mk(1, 5'd4,  0, 0, 0, 0, 64'h0, 64'h0));
        vec.push_back(mk(1, 5'd5,  1, 5'd6,  64'h0123456789ABCDEF, 8'h81,
                         64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA));
        vec.push_back(mk(1, 5'd6,  0, 0, 0, 0, 64'h01000000000000EF, 64'h01000000000000EF));
        vec.push_back(mk(0, 0,     0, 0, 0, 0, 0, 0));
        vec.push_back(mk(1, 5'd8,  0, 0, 0, 0, 64'h0, 64'h0));
        vec.push_back(mk(0, 0,     1, 5'd8,  64'h5555555555555555, 8'hFF, 0, 0));
        vec.push_back(mk(1, 5'd8,  0, 0, 0, 0, 64'h5555555555555555, 64'h5555555555555555));

        for (int i = 0; i < vec.size() + 2; i++) begin
            logic va, vb;
            if (i < vec.size()) drive(vec[i].re, vec[i].raddr, vec[i].we, vec[i].waddr,
                                      vec[i].wdata, vec[i].bwe);
            else idle();
            tick();
            vb = (i < vec.size()) && vec[i].re;
            va = (i >= 1) && (i - 1 < vec.size()) && vec[i-1].re;
            if (vb) last_b = vec[i].exp_b;
            if (va) last_a = vec[i-1].exp_a;
            check_outs($sformatf("vec%0d", i), va, vb);
        end

`ifdef RAM_BWE_PIPE_PARITY_EN
        dut_a.mem[9] = 64'h1;
        dut_b.mem[9] = 64'h1;
        drive(1'b1, 5'd9, 1'b0, '0, '0, '0);
        tick();
        idle();
        check_bit("par9 b.perr", bus_b.o_parity_err, 1'b1);
        check_bit("par9 b.rvalid", bus_b.o_mem_rvalid, 1'b1);
        tick();
        check_bit("par9 a.perr", bus_a.o_parity_err, 1'b1);
        check_bit("par9 a.rvalid", bus_a.o_mem_rvalid, 1'b1);
        check_bit("par9 b.perr_clr", bus_b.o_parity_err, 1'b0);
        drive(1'b1, 5'd5, 1'b0, '0, '0, '0);
        tick();
        idle();
        check_bit("par5 b.perr", bus_b.o_parity_err, 1'b0);
        tick();
        check_bit("par5 a.perr", bus_a.o_parity_err, 1'b0);
        check_bit("par5 a.rvalid", bus_a.o_mem_rvalid, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
